// File: rtl/mnist_pkg.sv
// mnist_pkg: shared logit/digit widths and inference sequencer state encoding
package mnist_pkg;
  localparam int LOGIT_W = 32;
  localparam int DIGIT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_AMAX  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;
endpackage

// File: rtl/argmax_scan.sv
// argmax_scan: running signed maximum over an index stream, ties keep the lowest index
module argmax_scan
  import mnist_pkg::*;
#(
  parameter int IDX_W = DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic [IDX_W-1:0]          idx,
  input  logic signed [LOGIT_W-1:0] val,
  output logic [IDX_W-1:0]          max_idx,
  output logic signed [LOGIT_W-1:0] max_val
);
  logic take;
  assign take = en && (idx == '0 || val > max_val);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (clr) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (take) begin
      max_idx <= idx;
      max_val <= val;
    end
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: runs layer engines in order with a per-layer watchdog, then scans logits for the argmax digit
module inference_sequencer
  import mnist_pkg::*;
#(
  parameter int NUM_LAYERS     = 2,
  parameter int OUT_DIM        = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int IDX_W          = DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      result_valid,
  output logic                      err_timeout,
  output logic [IDX_W-1:0]          err_layer,
  output logic [NUM_LAYERS-1:0]     layer_start,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  output logic                      layer_clr,
  output logic [IDX_W-1:0]          logit_addr,
  input  logic signed [LOGIT_W-1:0] logit_data,
  output logic [IDX_W-1:0]          predicted_digit,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic [31:0]               cycle_count
);
  localparam logic [31:0] WD_MAX = 32'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [IDX_W-1:0] lyr, amax_idx;
  logic [31:0] wd;
  logic armed, accept, lyr_done, last_layer, last_logit;
  logic signed [LOGIT_W-1:0] amax_val;
  logic [NUM_LAYERS-1:0] lyr_oh;
  assign accept     = state == S_IDLE && req && armed;
  assign lyr_oh     = NUM_LAYERS'(1) << lyr;
  assign lyr_done   = |(layer_done & lyr_oh);
  assign last_layer = lyr == IDX_W'(NUM_LAYERS - 1);
  assign last_logit = logit_addr == IDX_W'(OUT_DIM - 1);
  argmax_scan #(.IDX_W(IDX_W)) u_argmax (
    .clk,
    .rst_n,
    .clr(state == S_IDLE),
    .en(state == S_AMAX),
    .idx(logit_addr),
    .val(logit_data),
    .max_idx(amax_idx),
    .max_val(amax_val)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= S_IDLE;
      lyr             <= '0;
      wd              <= '0;
      armed           <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      result_valid    <= 1'b0;
      err_timeout     <= 1'b0;
      err_layer       <= '0;
      layer_start     <= '0;
      layer_clr       <= 1'b0;
      logit_addr      <= '0;
      predicted_digit <= '0;
      max_logit       <= '0;
      cycle_count     <= '0;
    end else begin
      layer_start <= '0;
      layer_clr   <= 1'b0;
      done        <= 1'b0;
      armed       <= accept ? 1'b0 : (!req ? 1'b1 : armed);
      if (state != S_IDLE && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
      // abort outranks every other transition, including completion
      if (state != S_IDLE && abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        layer_clr <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            state        <= S_START;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            cycle_count  <= '0;
            lyr          <= '0;
          end
          S_START: begin
            layer_start <= lyr_oh;
            wd          <= '0;
            state       <= S_WAIT;
          end
          S_WAIT: if (lyr_done) begin
            state      <= last_layer ? S_AMAX : S_START;
            lyr        <= last_layer ? lyr : lyr + 1'b1;
            logit_addr <= '0;
          end else if (wd == WD_MAX) state <= S_ERR;
          else wd <= wd + 32'd1;
          S_AMAX: begin
            logit_addr <= last_logit ? '0 : logit_addr + 1'b1;
            state      <= last_logit ? S_DONE : S_AMAX;
          end
          S_DONE: begin
            done            <= 1'b1;
            result_valid    <= 1'b1;
            predicted_digit <= amax_idx;
            max_logit       <= amax_val;
            busy            <= 1'b0;
            state           <= S_IDLE;
          end
          S_ERR: begin
            layer_clr   <= 1'b1;
            err_timeout <= 1'b1;
            err_layer   <= lyr;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: directed scenarios on a default instance and a short-watchdog instance
module tb_inference_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [2], abort [2], busy [2], done [2], result_valid [2], err_timeout [2], layer_clr [2];
  logic [3:0] err_layer [2], logit_addr [2], predicted_digit [2];
  logic [1:0] layer_start [2], layer_done [2];
  logic signed [31:0] logit_data [2], max_logit [2];
  logic [31:0] cycle_count [2];
  logic signed [31:0] logits [16];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign logit_data[0] = logits[logit_addr[0]];
  assign logit_data[1] = 32'sd0;
  inference_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
    .result_valid(result_valid[0]), .err_timeout(err_timeout[0]), .err_layer(err_layer[0]),
    .layer_start(layer_start[0]), .layer_done(layer_done[0]), .layer_clr(layer_clr[0]),
    .logit_addr(logit_addr[0]), .logit_data(logit_data[0]), .predicted_digit(predicted_digit[0]),
    .max_logit(max_logit[0]), .cycle_count(cycle_count[0])
  );
  inference_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
    .result_valid(result_valid[1]), .err_timeout(err_timeout[1]), .err_layer(err_layer[1]),
    .layer_start(layer_start[1]), .layer_done(layer_done[1]), .layer_clr(layer_clr[1]),
    .logit_addr(logit_addr[1]), .logit_data(logit_data[1]), .predicted_digit(predicted_digit[1]),
    .max_logit(max_logit[1]), .cycle_count(cycle_count[1])
  );
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic start_req(input int d);
    req[d] = 1'b1;
    tick();
    req[d] = 1'b0;
  endtask
  // waits for the layer's start pulse, then answers lat cycles later (lat < 0: never answers)
  task automatic run_layer(input int d, input int i, input int lat);
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = layer_start[d][i];
      if (!ok) tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL start_wait dut%0d layer%0d got 0 exp 1", d, i); end
    if (lat >= 0) begin
      repeat (lat) tick();
      layer_done[d][i] = 1'b1;
      tick();
      layer_done[d][i] = 1'b0;
    end
  endtask
  task automatic wait_done(input int d);
    bit ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      tick();
      ok = done[d];
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_wait dut%0d got 0 exp 1", d); end
  endtask
  task automatic test_reset();
    repeat (2) tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy[0]); end
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done got %0h exp 0", done[0]); end
    checks++; if (layer_start[0] !== 2'b00) begin errors++; $display("FAIL rst_start got %0h exp 0", layer_start[0]); end
    checks++; if (cycle_count[0] !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0h exp 0", cycle_count[0]); end
    checks++; if (err_timeout[1] !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", err_timeout[1]); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    int n = 0;
    for (int i = 0; i < 16; i++) logits[i] = 32'sd0;
    logits[0] = 32'sd5; logits[1] = -32'sd3; logits[2] = 32'sd9; logits[3] = 32'sd9;
    start_req(0);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", busy[0]); end
    run_layer(0, 0, 40);
    run_layer(0, 1, 12);
    wait_done(0);
    checks++; if (predicted_digit[0] !== 4'd2) begin errors++; $display("FAIL basic_digit got %0d exp 2", predicted_digit[0]); end
    checks++; if (max_logit[0] !== 32'sd9) begin errors++; $display("FAIL basic_max got %0d exp 9", max_logit[0]); end
    checks++; if (cycle_count[0] !== 32'd67) begin errors++; $display("FAIL basic_cycles got %0d exp 67", cycle_count[0]); end
    checks++; if (result_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", result_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle got %0h exp 0", busy[0]); end
    repeat (5) begin tick(); n += int'(done[0]); end
    checks++; if (n != 0) begin errors++; $display("FAIL basic_one_pulse got %0d exp 0", n); end
  endtask
  task automatic test_ties();
    for (int i = 0; i < 16; i++) logits[i] = 32'sh8000_0000;
    start_req(0);
    run_layer(0, 0, 3);
    run_layer(0, 1, 2);
    wait_done(0);
    checks++; if (predicted_digit[0] !== 4'd0) begin errors++; $display("FAIL tie_digit got %0d exp 0", predicted_digit[0]); end
    checks++; if (max_logit[0] !== 32'sh8000_0000) begin errors++; $display("FAIL tie_max got %0h exp 80000000", max_logit[0]); end
    for (int i = 0; i < 16; i++) logits[i] = -32'sd5;
    logits[9] = -32'sd1;
    start_req(0);
    run_layer(0, 0, 3);
    run_layer(0, 1, 2);
    wait_done(0);
    checks++; if (predicted_digit[0] !== 4'd9) begin errors++; $display("FAIL last_digit got %0d exp 9", predicted_digit[0]); end
    checks++; if (max_logit[0] !== -32'sd1) begin errors++; $display("FAIL last_max got %0d exp -1", max_logit[0]); end
  endtask
  task automatic test_timeout();
    int n = 0;
    bit saw_done = 1'b0;
    start_req(1);
    run_layer(1, 0, 3);
    run_layer(1, 1, -1);
    while (!layer_clr[1] && n < 40) begin tick(); n++; saw_done |= done[1]; end
    checks++; if (n != 17) begin errors++; $display("FAIL to_latency got %0d exp 17", n); end
    checks++; if (err_timeout[1] !== 1'b1) begin errors++; $display("FAIL to_flag got %0h exp 1", err_timeout[1]); end
    checks++; if (err_layer[1] !== 4'd1) begin errors++; $display("FAIL to_layer got %0d exp 1", err_layer[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL to_busy got %0h exp 0", busy[1]); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL to_nodone got %0h exp 0", saw_done); end
    tick();
    checks++; if (layer_clr[1] !== 1'b0) begin errors++; $display("FAIL to_clr_pulse got %0h exp 0", layer_clr[1]); end
    checks++; if (err_timeout[1] !== 1'b1) begin errors++; $display("FAIL to_sticky got %0h exp 1", err_timeout[1]); end
    start_req(1);
    checks++; if (err_timeout[1] !== 1'b0) begin errors++; $display("FAIL to_cleared got %0h exp 0", err_timeout[1]); end
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
  endtask
  task automatic test_abort();
    bit seen = 1'b0;
    start_req(0);
    run_layer(0, 0, -1);
    repeat (5) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checks++; if (layer_clr[0] !== 1'b1) begin errors++; $display("FAIL abw_clr got %0h exp 1", layer_clr[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abw_busy got %0h exp 0", busy[0]); end
    checks++; if (result_valid[0] !== 1'b0) begin errors++; $display("FAIL abw_valid got %0h exp 0", result_valid[0]); end
    checks++; if (predicted_digit[0] !== 4'd9) begin errors++; $display("FAIL abw_keep got %0d exp 9", predicted_digit[0]); end
    tick();
    checks++; if (layer_clr[0] !== 1'b0) begin errors++; $display("FAIL abw_clr_pulse got %0h exp 0", layer_clr[0]); end
    start_req(0);
    run_layer(0, 0, 2);
    run_layer(0, 1, 2);
    checks++; if (logit_addr[0] !== 4'd0) begin errors++; $display("FAIL addr0 got %0d exp 0", logit_addr[0]); end
    repeat (3) tick();
    checks++; if (logit_addr[0] !== 4'd3) begin errors++; $display("FAIL addr3 got %0d exp 3", logit_addr[0]); end
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checks++; if (layer_clr[0] !== 1'b1) begin errors++; $display("FAIL aba_clr got %0h exp 1", layer_clr[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL aba_busy got %0h exp 0", busy[0]); end
    repeat (15) begin tick(); seen |= done[0]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL aba_nodone got %0h exp 0", seen); end
    checks++; if (result_valid[0] !== 1'b0) begin errors++; $display("FAIL aba_valid got %0h exp 0", result_valid[0]); end
    start_req(0);
    run_layer(0, 0, -1);
    repeat (3) tick();
    layer_done[0][0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    layer_done[0][0] = 1'b0;
    abort[0] = 1'b0;
    checks++; if (layer_clr[0] !== 1'b1) begin errors++; $display("FAIL abd_clr got %0h exp 1", layer_clr[0]); end
    seen = 1'b0;
    repeat (5) begin tick(); seen |= layer_start[0][1] | busy[0]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abd_wins got %0h exp 0", seen); end
  endtask
  task automatic test_req_handling();
    int n = 0;
    bit seen = 1'b0;
    req[0] = 1'b1;
    tick();
    run_layer(0, 0, 3);
    run_layer(0, 1, 3);
    wait_done(0);
    repeat (20) begin tick(); n += int'(busy[0]); end
    checks++; if (n != 0) begin errors++; $display("FAIL held_rerun got %0d exp 0", n); end
    checks++; if (result_valid[0] !== 1'b1) begin errors++; $display("FAIL held_valid got %0h exp 1", result_valid[0]); end
    req[0] = 1'b0;
    tick();
    start_req(0);
    run_layer(0, 0, -1);
    repeat (2) tick();
    layer_done[0][1] = 1'b1;
    tick();
    layer_done[0][1] = 1'b0;
    repeat (2) begin tick(); seen |= layer_start[0][1]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stray_done got %0h exp 0", seen); end
    layer_done[0][0] = 1'b1;
    tick();
    layer_done[0][0] = 1'b0;
    run_layer(0, 1, 2);
    wait_done(0);
    checks++; if (cycle_count[0] !== 32'd22) begin errors++; $display("FAIL rerun_cycles got %0d exp 22", cycle_count[0]); end
    checks++; if (predicted_digit[0] !== 4'd9) begin errors++; $display("FAIL rerun_digit got %0d exp 9", predicted_digit[0]); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) logits[i] = 32'(i);
    logits[7] = 32'sd100;
    start_req(0);
    run_layer(0, 0, 2);
    run_layer(0, 1, 2);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ar_busy got %0h exp 0", busy[0]); end
    checks++; if (logit_addr[0] !== 4'd0) begin errors++; $display("FAIL ar_addr got %0d exp 0", logit_addr[0]); end
    checks++; if (predicted_digit[0] !== 4'd0) begin errors++; $display("FAIL ar_digit got %0d exp 0", predicted_digit[0]); end
    checks++; if (cycle_count[0] !== 32'd0) begin errors++; $display("FAIL ar_cycles got %0d exp 0", cycle_count[0]); end
    checks++; if (max_logit[0] !== 32'sd0) begin errors++; $display("FAIL ar_max got %0d exp 0", max_logit[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_req(0);
    run_layer(0, 0, 4);
    run_layer(0, 1, 4);
    wait_done(0);
    checks++; if (predicted_digit[0] !== 4'd7) begin errors++; $display("FAIL post_digit got %0d exp 7", predicted_digit[0]); end
    checks++; if (max_logit[0] !== 32'sd100) begin errors++; $display("FAIL post_max got %0d exp 100", max_logit[0]); end
    checks++; if (cycle_count[0] !== 32'd23) begin errors++; $display("FAIL post_cycles got %0d exp 23", cycle_count[0]); end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      abort[d] = 1'b0;
      layer_done[d] = 2'b00;
    end
    for (int i = 0; i < 16; i++) logits[i] = 32'sd0;
    test_reset();
    test_basic();
    test_ties();
    test_timeout();
    test_abort();
    test_req_handling();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule
